dac_segment_encoder: RTL and testbench

// - Parametrised digital front-end for the segmented current-steering DAC.
// - Turns a binary sample code into complementary thermometer and binary unit-select vectors.
// - Its outputs drive the retiming flip-flop bank.
// - Adds data-weighted-averaging (DWA) rotation of the thermometer units.
// - Adds a per-unit calibration sequencer that drives the dataical path.

---
 rtl/dac_pkg.sv | 33 +++
 rtl/dac_segment_encoder_if.sv | 46 ++++
 rtl/dwa_rotator.sv | 47 ++++
 rtl/dac_segment_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_dac_segment_encoder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared types and helpers for the segmented DAC front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_pkg;

    // Calibration sequencer states.
    typedef enum logic [1:0] {
        CAL_IDLE  = 2'd0,
        CAL_SWEEP = 2'd1,
        CAL_DONE  = 2'd2
    } cal_state_e;

    // Default geometry of the converter.
    localparam int DEF_NTHERM    = 17;
    localparam int DEF_NBIN      = 6;
    localparam int DEF_CODE_W    = 11;
    localparam int DEF_CAL_DWELL = 256;

    // Largest code the array can represent: every thermometer unit plus a
    // full binary LSB section.
    function automatic int max_code(input int ntherm, input int nbin);
        return ntherm * (1 << nbin) + (1 << nbin) - 1;
    endfunction

    // Units visited by the calibration sweep: thermometer cells, then the
    // binary cells including the redundant LSB.
    function automatic int unit_count(input int ntherm, input int nbin);
        return ntherm + nbin + 1;
    endfunction

    localparam int NUNITS = unit_count(DEF_NTHERM, DEF_NBIN);

endpackage

// File: rtl/dac_segment_encoder_if.sv
// Sample/control/select bundle between the sample source and the encoder.
// Latency: n/a (wiring only).
// Backpressure: none; code_valid qualifies samples, there is no ready.
//
// Ports (slave = encoder side):
//   code, code_valid, dwa_en, cal_start, cal_abort       -> into encoder
//   dataintherm(b), datainbin(b), dataical, cal_busy,
//   cal_done, cal_idx, ovf                               <- out of encoder
interface dac_segment_encoder_if
    import dac_pkg::*;
#(
    parameter int NTHERM = DEF_NTHERM,
    parameter int NBIN   = DEF_NBIN,
    parameter int CODE_W = DEF_CODE_W
);
    localparam int IDX_W = $clog2(unit_count(NTHERM, NBIN));

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              dwa_en;
    logic              cal_start;
    logic              cal_abort;

    logic [NTHERM-1:0] dataintherm;
    logic [NTHERM-1:0] datainthermb;
    logic [NBIN:0]     datainbin;
    logic [NBIN:0]     datainbinb;
    logic              dataical;
    logic              cal_busy;
    logic              cal_done;
    logic [IDX_W-1:0]  cal_idx;
    logic              ovf;

    modport master (
        output code, code_valid, dwa_en, cal_start, cal_abort,
        input  dataintherm, datainthermb, datainbin, datainbinb,
               dataical, cal_busy, cal_done, cal_idx, ovf
    );

    modport slave (
        input  code, code_valid, dwa_en, cal_start, cal_abort,
        output dataintherm, datainthermb, datainbin, datainbinb,
               dataical, cal_busy, cal_done, cal_idx, ovf
    );

endinterface

// File: rtl/dwa_rotator.sv
// Builds a k-unit thermometer mask rotated to start at ptr; returns next ptr.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   k_i        number of units to select, 0..NTHERM
//   ptr_i      first unit of the run, 0..NTHERM-1
//   therm_o    selected units, wrapping modulo NTHERM
//   ptr_nxt_o  (ptr_i + k_i) mod NTHERM
module dwa_rotator
    import dac_pkg::*;
#(
    parameter int NTHERM = DEF_NTHERM,
    parameter int KW     = $clog2(NTHERM + 1),
    parameter int PW     = $clog2(NTHERM)
) (
    input  logic [KW-1:0]     k_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [NTHERM-1:0] therm_o,
    output logic [PW-1:0]     ptr_nxt_o
);

    logic [NTHERM-1:0]   base;
    logic [2*NTHERM-1:0] spread;
    logic [PW:0]         sum;

    always_comb begin
        base = '0;
        for (int i = 0; i < NTHERM; i++) begin
            base[i] = (i < int'(k_i));
        end

        // Shift the unrotated mask into a double-width window and fold the
        // overflow half back onto the bottom: a rotate-left by ptr_i.
        spread  = {{NTHERM{1'b0}}, base} << ptr_i;
        therm_o = spread[NTHERM-1:0] | spread[2*NTHERM-1:NTHERM];

        // ptr_i < NTHERM and k_i <= NTHERM, so one conditional subtract
        // is a full modulo; k_i == NTHERM lands back on ptr_i.
        sum = (PW+1)'(ptr_i) + (PW+1)'(k_i);
        if (sum >= (PW+1)'(NTHERM)) begin
            sum = sum - (PW+1)'(NTHERM);
        end
        ptr_nxt_o = sum[PW-1:0];
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// Segmented DAC front-end: saturate, split, DWA-rotate and calibration-sweep.
// Latency: 2 cycles code -> unit selects; calibration selects follow FSM state.
// Backpressure: none; code_valid low holds outputs, codes ignored while sweeping.
//
// Ports:
//   clkin   sample clock (rising edge)
//   pdb     async active-low reset / power-down
//   bus     slave side of dac_segment_encoder_if (code in, unit selects out)
module dac_segment_encoder
    import dac_pkg::*;
#(
    parameter int NTHERM    = DEF_NTHERM,
    parameter int NBIN      = DEF_NBIN,
    parameter int CODE_W    = DEF_CODE_W,
    parameter int CAL_DWELL = DEF_CAL_DWELL
) (
    input  logic                  clkin,
    input  logic                  pdb,
    dac_segment_encoder_if.slave  bus
);

    localparam int UNITS = unit_count(NTHERM, NBIN);
    localparam int IDX_W = $clog2(UNITS);
    localparam int KW    = $clog2(NTHERM + 1);
    localparam int PW    = $clog2(NTHERM);
    localparam int DW_W  = $clog2(CAL_DWELL + 1);

    localparam logic [CODE_W-1:0] MAXC = CODE_W'(max_code(NTHERM, NBIN));

    // ------------------------------------------------------------------
    // Calibration sequencer state
    // ------------------------------------------------------------------
    cal_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              sweep;

    assign sweep = (state_q == CAL_SWEEP);

    // ------------------------------------------------------------------
    // Stage 1: saturate and split
    // ------------------------------------------------------------------
    logic              s1_vld_q;
    logic [KW-1:0]     s1_k_q;
    logic [NBIN-1:0]   s1_lsb_q;
    logic              s1_dwa_q;
    logic              ovf_q;

    logic              code_big;
    logic [CODE_W-1:0] code_sat;

    assign code_big = (bus.code > MAXC);
    assign code_sat = code_big ? MAXC : bus.code;

    // While sweeping the stage is frozen, so whatever it held on entry is
    // decoded exactly once when the sweep ends.
    always_ff @(posedge clkin or negedge pdb) begin
        if (!pdb) begin
            s1_vld_q <= 1'b0;
            s1_k_q   <= '0;
            s1_lsb_q <= '0;
            s1_dwa_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!sweep) begin
            s1_vld_q <= bus.code_valid;
            if (bus.code_valid) begin
                s1_k_q   <= KW'(code_sat >> NBIN);
                s1_lsb_q <= code_sat[NBIN-1:0];
                s1_dwa_q <= bus.dwa_en;
                if (code_big) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: decode / rotate, register selects
    // ------------------------------------------------------------------
    logic [NTHERM-1:0] therm_q;
    logic [NBIN:0]     bin_q;
    logic [PW-1:0]     ptr_q;

    logic [PW-1:0]     rot_ptr;
    logic [NTHERM-1:0] rot_therm;
    logic [PW-1:0]     rot_ptr_nxt;

    // Static mode is a rotation from unit 0; the DWA pointer is left alone
    // so switching back to DWA continues where it stopped.
    assign rot_ptr = s1_dwa_q ? ptr_q : '0;

    dwa_rotator #(
        .NTHERM (NTHERM),
        .KW     (KW),
        .PW     (PW)
    ) u_rot (
        .k_i       (s1_k_q),
        .ptr_i     (rot_ptr),
        .therm_o   (rot_therm),
        .ptr_nxt_o (rot_ptr_nxt)
    );

    always_ff @(posedge clkin or negedge pdb) begin
        if (!pdb) begin
            therm_q <= '0;
            bin_q   <= '0;
            ptr_q   <= '0;
        end else if (!sweep && s1_vld_q) begin
            therm_q <= rot_therm;
            bin_q   <= {s1_lsb_q, 1'b0};
            if (s1_dwa_q) begin
                ptr_q <= rot_ptr_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Calibration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clkin or negedge pdb) begin
        if (!pdb) begin
            state_q <= CAL_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;

        case (state_q)
            CAL_IDLE: begin
                if (bus.cal_start) begin
                    state_d = CAL_SWEEP;
                    idx_d   = '0;
                    dwell_d = '0;
                end
            end
            CAL_SWEEP: begin
                if (dwell_q == DW_W'(CAL_DWELL - 1)) begin
                    dwell_d = '0;
                    if (idx_q == IDX_W'(UNITS - 1)) begin
                        state_d = CAL_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            CAL_DONE: begin
                state_d = CAL_IDLE;
            end
            default: begin
                state_d = CAL_IDLE;
            end
        endcase

        // Abort overrides everything, including the final-dwell exit, so an
        // aborted sweep never produces cal_done.
        if (bus.cal_abort) begin
            state_d = CAL_IDLE;
            idx_d   = '0;
            dwell_d = '0;
        end
    end

    // One-hot over the full unit list: therm cells first, then bin[0..NBIN].
    logic [UNITS-1:0] cal_onehot;

    always_comb begin
        cal_onehot = '0;
        for (int i = 0; i < UNITS; i++) begin
            cal_onehot[i] = (int'(idx_q) == i);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: complements derived from the same select so the pairs can
    // never disagree, including in reset.
    // ------------------------------------------------------------------
    logic [NTHERM-1:0] sel_therm;
    logic [NBIN:0]     sel_bin;

    assign sel_therm = sweep ? cal_onehot[NTHERM-1:0]     : therm_q;
    assign sel_bin   = sweep ? cal_onehot[UNITS-1:NTHERM] : bin_q;

    assign bus.dataintherm  = sel_therm;
    assign bus.datainthermb = ~sel_therm;
    assign bus.datainbin    = sel_bin;
    assign bus.datainbinb   = ~sel_bin;
    assign bus.dataical     = sweep;
    assign bus.cal_busy     = (state_q != CAL_IDLE);
    assign bus.cal_done     = (state_q == CAL_DONE);
    assign bus.cal_idx      = idx_q;
    assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Self-checking bench for dac_segment_encoder: vector table, corner sequences,
// random traffic against an arithmetic reference model, per-cycle checker.
// Inputs driven on falling edges; outputs sampled on falling edges.
module tb_dac_segment_encoder;

    localparam int NT   = 17;
    localparam int NB   = 6;
    localparam int CW   = 11;
    localparam int DW   = 4;
    localparam int NU   = dac_pkg::NUNITS;
    localparam int MAXC = NT * 64 + 63;

    logic clkin = 1'b0;
    logic pdb;

    always #5 clkin = ~clkin;

    dac_segment_encoder_if #(.NTHERM(NT), .NBIN(NB), .CODE_W(CW)) dif ();

    dac_segment_encoder #(
        .NTHERM    (NT),
        .NBIN      (NB),
        .CODE_W    (CW),
        .CAL_DWELL (DW)
    ) dut (
        .clkin (clkin),
        .pdb   (pdb),
        .bus   (dif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending sample, output image, pointer, and a
    // calibration mode with elapsed-cycle count (unit = elapsed / DW).
    // ------------------------------------------------------------------
    int           m_ptr, m_mode, m_t;
    logic [NT-1:0] m_therm;
    logic [NB:0]   m_bin;
    bit            m_ovf;
    bit            p_v, p_dwa;
    int            p_k, p_lsb;
    int            mc, mb;

    always @(posedge clkin or negedge pdb) begin
        if (!pdb) begin
            m_ptr = 0; m_mode = 0; m_t = 0;
            m_therm = '0; m_bin = '0; m_ovf = 0;
            p_v = 0; p_dwa = 0; p_k = 0; p_lsb = 0;
        end else begin
            if (m_mode != 1 && p_v) begin
                mb = p_dwa ? m_ptr : 0;
                m_therm = '0;
                for (int j = 0; j < p_k; j++) m_therm[(mb + j) % NT] = 1'b1;
                m_bin = {p_lsb[NB-1:0], 1'b0};
                if (p_dwa) m_ptr = (m_ptr + p_k) % NT;
            end
            if (m_mode != 1) begin
                p_v = dif.code_valid;
                if (dif.code_valid) begin
                    mc = int'(dif.code);
                    if (mc > MAXC) begin
                        mc = MAXC;
                        m_ovf = 1;
                    end
                    p_k   = mc / 64;
                    p_lsb = mc % 64;
                    p_dwa = dif.dwa_en;
                end
            end
            if (dif.cal_abort) m_mode = 0;
            else case (m_mode)
                0: if (dif.cal_start) begin m_mode = 1; m_t = 0; end
                1: begin m_t++; if (m_t == NU * DW) m_mode = 2; end
                default: m_mode = 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle checker against the model (includes complement pairs).
    // ------------------------------------------------------------------
    bit            chk_en = 0;
    logic [NT-1:0] e_therm, e_thermb;
    logic [NB:0]   e_bin, e_binb;
    int            e_idx, e_u;
    bit            e_cal;

    always @(negedge clkin) begin
        if (chk_en && pdb) begin
            if (m_mode == 1) begin
                e_u = m_t / DW;
                e_therm = '0; e_bin = '0;
                if (e_u < NT) e_therm[e_u] = 1'b1;
                else e_bin[e_u - NT] = 1'b1;
                e_idx = e_u; e_cal = 1;
            end else begin
                e_therm = m_therm; e_bin = m_bin; e_idx = 0; e_cal = 0;
            end
            e_thermb = ~e_therm;
            e_binb   = ~e_bin;
            chk("cyc_therm",  dif.dataintherm,  e_therm);
            chk("cyc_thermb", dif.datainthermb, e_thermb);
            chk("cyc_bin",    dif.datainbin,    e_bin);
            chk("cyc_binb",   dif.datainbinb,   e_binb);
            chk("cyc_ical",   dif.dataical,     e_cal);
            chk("cyc_busy",   dif.cal_busy,     m_mode != 0);
            chk("cyc_done",   dif.cal_done,     m_mode == 2);
            chk("cyc_idx",    dif.cal_idx,      e_idx);
            chk("cyc_ovf",    dif.ovf,          m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic apply(input int c, input bit d);
        dif.code = CW'(c);
        dif.dwa_en = d;
        dif.code_valid = 1'b1;
        @(negedge clkin);
        dif.code_valid = 1'b0;
        @(negedge clkin);
    endtask

    task automatic rand_code();
        dif.code = CW'($urandom_range(0, 2047));
        dif.code_valid = ($urandom_range(0, 3) != 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_therm"},  dif.dataintherm,  17'h00000);
        chk({tag, "_thermb"}, dif.datainthermb, 17'h1FFFF);
        chk({tag, "_bin"},    dif.datainbin,    7'h00);
        chk({tag, "_binb"},   dif.datainbinb,   7'h7F);
        chk({tag, "_ovf"},    dif.ovf,          1'b0);
        chk({tag, "_busy"},   dif.cal_busy,     1'b0);
        chk({tag, "_ical"},   dif.dataical,     1'b0);
        chk({tag, "_idx"},    dif.cal_idx,      0);
    endtask

    typedef struct {
        int            code;
        bit            dwa;
        logic [NT-1:0] therm;
        logic [NB:0]   bin;
        bit            ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n_ical, n_done;
        bit found, seen_done;

        // Expected values derived by hand from the code split rules.
        tbl[0] = '{200,  1'b0, 17'h00007, 7'h10, 1'b0}; // k=3 lsb=8
        tbl[1] = '{640,  1'b1, 17'h003FF, 7'h00, 1'b0}; // units 0-9, ptr->10
        tbl[2] = '{640,  1'b1, 17'h1FC07, 7'h00, 1'b0}; // 10-16,0-2, ptr->3
        tbl[3] = '{1088, 1'b1, 17'h1FFFF, 7'h00, 1'b0}; // k=17, ptr stays 3
        tbl[4] = '{64,   1'b1, 17'h00008, 7'h00, 1'b0}; // unit 3, ptr->4
        tbl[5] = '{133,  1'b1, 17'h00030, 7'h0A, 1'b0}; // units 4,5 lsb=5, ptr->6
        tbl[6] = '{2047, 1'b0, 17'h1FFFF, 7'h7E, 1'b1}; // clamp to 1151
        tbl[7] = '{0,    1'b0, 17'h00000, 7'h00, 1'b1}; // ovf sticky

        dif.code = '0; dif.code_valid = 0; dif.dwa_en = 0;
        dif.cal_start = 0; dif.cal_abort = 0;
        pdb = 1'b1;
        #1 pdb = 1'b0;
        #1 reset_checks("rst0");
        @(negedge clkin);
        @(negedge clkin);
        pdb = 1'b1;
        chk_en = 1;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].code, tbl[i].dwa);
            chk($sformatf("tbl%0d_therm", i), dif.dataintherm, tbl[i].therm);
            chk($sformatf("tbl%0d_bin", i),   dif.datainbin,   tbl[i].bin);
            chk($sformatf("tbl%0d_bin0", i),  dif.datainbin[0], 1'b0);
            chk($sformatf("tbl%0d_ovf", i),   dif.ovf,         tbl[i].ovf);
        end

        // Hold: ptr is 6 here. Units 6,7 selected, then 10 invalid cycles
        // with dwa_en toggling, then one unit must land on 8.
        apply(133, 1'b1);
        for (int i = 0; i < 10; i++) begin
            dif.code = CW'($urandom_range(0, 2047));
            dif.dwa_en = i[0];
            @(negedge clkin);
            chk("hold_therm", dif.dataintherm, 17'h000C0);
            chk("hold_bin",   dif.datainbin,   7'h0A);
        end
        apply(64, 1'b1);
        chk("hold_ptr", dif.dataintherm, 17'h00100);

        // Full sweep with random codes offered (and ignored) meanwhile,
        // plus a cal_start while busy.
        dif.dwa_en = 1'b1;
        dif.cal_start = 1'b1;
        @(negedge clkin);
        dif.cal_start = 1'b0;
        n_ical = 0; n_done = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (dif.dataical) n_ical++;
            if (dif.cal_done) n_done++;
            rand_code();
            dif.cal_start = (cyc == 10);
            @(negedge clkin);
        end
        dif.code_valid = 1'b0;
        chk("sweep_ical_cycles", n_ical, NU * DW);
        chk("sweep_done_pulses", n_done, 1);

        // Abort at unit 5.
        dif.cal_start = 1'b1;
        @(negedge clkin);
        dif.cal_start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dif.cal_idx == 5) begin found = 1; break; end
            @(negedge clkin);
        end
        chk("abort_reach_unit5", found, 1'b1);
        dif.cal_abort = 1'b1;
        @(negedge clkin);
        dif.cal_abort = 1'b0;
        chk("abort_busy", dif.cal_busy, 1'b0);
        chk("abort_ical", dif.dataical, 1'b0);
        seen_done = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (dif.cal_done) seen_done = 1;
            @(negedge clkin);
        end
        chk("abort_no_done", seen_done, 1'b0);

        // Abort and start together: abort wins.
        dif.cal_start = 1'b1; dif.cal_abort = 1'b1;
        @(negedge clkin);
        dif.cal_start = 1'b0; dif.cal_abort = 1'b0;
        chk("abort_start_busy", dif.cal_busy, 1'b0);

        // Random traffic.
        for (int cyc = 0; cyc < 400; cyc++) begin
            rand_code();
            dif.dwa_en    = ($urandom_range(0, 7) != 0);
            dif.cal_start = ($urandom_range(0, 99) == 0);
            dif.cal_abort = ($urandom_range(0, 199) == 0);
            @(negedge clkin);
        end
        dif.cal_start = 0; dif.cal_abort = 0; dif.code_valid = 0;

        // Reset mid-sweep, asynchronously between edges.
        dif.cal_start = 1'b1;
        @(negedge clkin);
        dif.cal_start = 1'b0;
        repeat (5) @(negedge clkin);
        #2 pdb = 1'b0;
        #1 reset_checks("rst_mid");
        @(negedge clkin);
        pdb = 1'b1;
        apply(200, 1'b0);
        chk("post_rst_static", dif.dataintherm, 17'h00007);
        apply(64, 1'b1);
        chk("post_rst_ptr0", dif.dataintherm, 17'h00001);
        chk("post_rst_ovf", dif.ovf, 1'b0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
